mem_port_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between two requesters.
- Requester 0 is the multicycle core's memory port (fetch/load/store, address already muxed by the core).
- Requester 1 is the program loader/debug port.
- Serialises accesses and inserts a fixed number of memory wait states. Returns read data and a one-cycle ready pulse to the winning requester.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/arb_pick2.sv | 37 +++
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter: state encoding,
// requester indices and default bus widths.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } arb_state_e;

  localparam int unsigned REQ_CORE   = 0;
  localparam int unsigned REQ_LOADER = 1;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned CNT_W      = 4;

endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker producing a one-hot grant.
// ARB_ROUND_ROBIN_EN selects alternating priority on contention; otherwise requester 0 wins.
module arb_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req0 && i_req1) begin
`ifdef ARB_ROUND_ROBIN_EN
      // i_last_grant holds the index of the previous winner; the other side goes now.
      if (i_last_grant) begin
        o_gnt[REQ_CORE] = 1'b1;
      end else begin
        o_gnt[REQ_LOADER] = 1'b1;
      end
`else
      o_gnt[REQ_CORE] = 1'b1;
`endif
    end else if (i_req0) begin
      o_gnt[REQ_CORE] = 1'b1;
    end else if (i_req1) begin
      o_gnt[REQ_LOADER] = 1'b1;
    end
  end

`ifndef ARB_ROUND_ROBIN_EN
  logic w_unused_last_grant;
  assign w_unused_last_grant = i_last_grant;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises core and loader accesses onto one single-port memory with WAIT_CYCLES wait states.
// Optional round-robin contention policy enabled by defining ARB_ROUND_ROBIN_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ready,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        gnt,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] WaitCnt = CNT_W'(WAIT_CYCLES);

  arb_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_gnt;
  logic              r_ready0;
  logic              r_ready1;
  logic              r_busy;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic [1:0]        w_pick;
  logic              w_last_grant;
  logic              w_issue;

  arb_pick2 u_pick (
    .i_req0       (r0_req),
    .i_req1       (r1_req),
    .i_last_grant (w_last_grant),
    .o_gnt        (w_pick)
  );

  assign w_issue = (r_state == StIdle) && (w_pick != 2'b00);

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  // Reset value 1 lets requester 0 win the first contended arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;
    end else if (w_issue) begin
      r_last_grant <= w_pick[REQ_LOADER];
    end
  end

  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_gnt       <= 2'b00;
      r_ready0    <= 1'b0;
      r_ready1    <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_ready0 <= 1'b0;
      r_ready1 <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_issue) begin
            r_gnt    <= w_pick;
            r_busy   <= 1'b1;
            r_mem_en <= 1'b1;
            r_cnt    <= WaitCnt;
            r_state  <= StAccess;
            if (w_pick[REQ_LOADER]) begin
              r_mem_we    <= r1_we;
              r_mem_addr  <= r1_addr;
              r_mem_wdata <= r1_wdata;
            end else begin
              r_mem_we    <= r0_we;
              r_mem_addr  <= r0_addr;
              r_mem_wdata <= r0_wdata;
            end
          end
        end
        StAccess: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            if (!r_mem_we) begin
              r_rdata <= mem_rdata;
            end
            r_ready0    <= r_gnt[REQ_CORE];
            r_ready1    <= r_gnt[REQ_LOADER];
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_state     <= StResp;
          end
        end
        StResp: begin
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign r0_ready  = r_ready0;
  assign r1_ready  = r_ready1;
  assign rdata     = r_rdata;
  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of the arbitration and memory contents.
module tb_mem_port_arbiter;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned WAIT = 1;
  localparam int          LAT  = WAIT + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [AW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_ready, r1_ready, busy, mem_en, mem_we;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [1:0]    gnt;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .WAIT_CYCLES (WAIT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .r0_req    (r0_req),
    .r0_we     (r0_we),
    .r0_addr   (r0_addr),
    .r0_wdata  (r0_wdata),
    .r0_ready  (r0_ready),
    .r1_req    (r1_req),
    .r1_we     (r1_we),
    .r1_addr   (r1_addr),
    .r1_wdata  (r1_wdata),
    .r1_ready  (r1_ready),
    .rdata     (rdata),
    .gnt       (gnt),
    .busy      (busy),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0101);
  endfunction

  // Memory stand-in: 256 words, contents restored on reset.
  logic [31:0] sim_mem [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) sim_mem[i] <= dflt(i);
      sim_mem[16] <= 32'hDEADBEEF;
    end else if (mem_en && mem_we) begin
      sim_mem[mem_addr[9:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = sim_mem[mem_addr[9:2]];

  // Reference model state.
  logic [31:0] exp_mem [256];
  logic [31:0] exp_rdata;
  int          m_last;

  task automatic model_reset();
    for (int i = 0; i < 256; i++) exp_mem[i] = dflt(i);
    exp_mem[16] = 32'hDEADBEEF;
    exp_rdata   = '0;
    m_last      = 1;
  endtask

  function automatic int pick(input bit q0, input bit q1, input int last);
    if (q0 && q1) begin
`ifdef ARB_ROUND_ROBIN_EN
      return (last == 0) ? 1 : 0;
`else
      return (last < 0) ? 1 : 0;
`endif
    end
    return q0 ? 0 : 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_mem_en"}, 64'(mem_en), 64'd0);
    chk({tag, "_mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_ready"}, 64'({r1_ready, r0_ready}), 64'd0);
  endtask

  // Called at the negedge of an IDLE cycle; returns at the negedge of the following IDLE cycle.
  task automatic do_txn(input bit q0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                        input bit q1, input bit we1, input logic [31:0] a1, input logic [31:0] d1,
                        input int drop, input bit keep, output int won);
    int          w;
    bit          we;
    logic [31:0] a, d;
    w      = pick(q0, q1, m_last);
    m_last = w;
    we     = (w == 1) ? we1 : we0;
    a      = (w == 1) ? a1 : a0;
    d      = (w == 1) ? d1 : d0;
    if (we) exp_mem[a[9:2]] = d;
    else    exp_rdata = exp_mem[a[9:2]];
    r0_req = q0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
    r1_req = q1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
    won = -1;
    for (int n = 1; n <= LAT; n++) begin
      @(negedge clk);
      if (n == drop) begin
        r0_req = 1'b0;
        r1_req = 1'b0;
      end
      chk("txn_gnt", 64'(gnt), (w == 1) ? 64'd2 : 64'd1);
      chk("txn_busy", 64'(busy), 64'd1);
      if (n < LAT) begin
        chk("acc_mem_en", 64'(mem_en), 64'd1);
        chk("acc_mem_we", 64'(mem_we), 64'(we));
        chk("acc_mem_addr", 64'(mem_addr), 64'(a));
        chk("acc_mem_wdata", 64'(mem_wdata), 64'(d));
        chk("acc_ready", 64'({r1_ready, r0_ready}), 64'd0);
      end else begin
        chk("resp_mem_en", 64'(mem_en), 64'd0);
        chk("resp_ready", 64'({r1_ready, r0_ready}), (w == 1) ? 64'd2 : 64'd1);
        chk("resp_rdata", 64'(rdata), 64'(exp_rdata));
        won = r1_ready ? 1 : (r0_ready ? 0 : -1);
      end
    end
    if (!keep) begin
      r0_req = 1'b0;
      r1_req = 1'b0;
    end
    @(negedge clk);
    check_idle("post");
    chk("post_rdata", 64'(rdata), 64'(exp_rdata));
  endtask

  initial begin
    int won;
    int exp_seq [4];
    bit keep, prev_keep;
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif

    // Reset, then ten idle cycles.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("rst");
    chk("rst_rdata", 64'(rdata), 64'd0);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_idle("idle");
    end

    // Single core read.
    do_txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, won);
    chk("rd_won", 64'(won), 64'd0);
    chk("rd_deadbeef", 64'(rdata), 64'hDEADBEEF);

    // Loader write leaves rdata unchanged, then read it back from the core.
    do_txn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h100, 32'h12345678, 0, 1'b0, won);
    chk("wr_won", 64'(won), 64'd1);
    chk("wr_rdata_kept", 64'(rdata), 64'hDEADBEEF);
    do_txn(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, won);
    chk("rdback", 64'(rdata), 64'h12345678);

    // Request dropped one cycle after grant.
    do_txn(1'b1, 1'b0, 32'h80, 32'h5, 1'b0, 1'b0, 32'h0, 32'h0, 1, 1'b0, won);
    chk("drop_won", 64'(won), 64'd0);

    // Contention with both requests held high, starting from reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      do_txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0, 0, k < 3, won);
      chk("contend_seq", 64'(won), 64'(exp_seq[k]));
    end

    // Reset in the middle of an access abandons it.
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h40;
    @(negedge clk);
    chk("mid_mem_en", 64'(mem_en), 64'd1);
    rst = 1'b1;
    r0_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_idle("midrst");
    chk("midrst_rdata", 64'(rdata), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("midrst_after");
    end
    do_txn(1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 1'b0, won);
    chk("midrst_service", 64'(rdata), 64'hDEADBEEF);

    // Randomized transactions.
    prev_keep = 1'b0;
    for (int t = 0; t < 80; t++) begin
      int          qs, drop, gap;
      logic [31:0] a0, a1;
      qs   = $urandom_range(1, 3);
      a0   = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
      a1   = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(1, WAIT + 1) : 0;
      keep = (t < 79) && (drop == 0) && ($urandom_range(0, 2) == 0);
      if (!prev_keep) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check_idle("gap");
        end
      end
      do_txn(qs[0], 1'($urandom_range(0, 1)), a0, $urandom,
             qs[1], 1'($urandom_range(0, 1)), a1, $urandom, drop, keep, won);
      chk("rand_won", 64'(won), 64'(m_last));
      prev_keep = keep;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
